// File: rtl/iob_axis_sim_loopback_pkg.sv
// iob_axis_sim_loopback shared package: default parameters,
// stall LFSR seed/taps/mask and the LFSR step function.
package iob_axis_sim_loopback_pkg;

  localparam int DEF_N_CH     = 1;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH_W  = 4;
  localparam int DEF_PKT_MODE = 0;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shift left
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [1:0]  STALL_MASK = 2'b11;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/iob_axis_sim_loopback_ch.sv
// iob_axis_sim_loopback_ch: one loopback channel (FIFO, level,
// packet count, sticky overflow, optional stall LFSR).
// Ports: clk_i, cke_i, arst_i, flush_i; s_t{valid,data,last}_i,
//   s_tready_o; m_t{valid,data,last}_o, m_tready_i; level_o, ovf_o.
// Macro IOB_AXIS_SIM_LOOPBACK_STALL_EN adds pseudo-random stalls.
module iob_axis_sim_loopback_ch
  import iob_axis_sim_loopback_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH_W  = DEF_DEPTH_W,
  parameter int PKT_MODE = DEF_PKT_MODE,
  parameter int CH_IDX   = 0
) (
  input  logic               clk_i,
  input  logic               cke_i,
  input  logic               arst_i,
  input  logic               flush_i,
  input  logic               s_tvalid_i,
  input  logic [DATA_W-1:0]  s_tdata_i,
  input  logic               s_tlast_i,
  output logic               s_tready_o,
  output logic               m_tvalid_o,
  output logic [DATA_W-1:0]  m_tdata_o,
  output logic               m_tlast_o,
  input  logic               m_tready_i,
  output logic [DEPTH_W:0]   level_o,
  output logic               ovf_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_LVL = DEPTH[DEPTH_W:0];

  logic [DATA_W:0]    mem [DEPTH];
  logic [DEPTH_W-1:0] wptr;
  logic [DEPTH_W-1:0] rptr;
  logic [DEPTH_W:0]   level;
  logic [DEPTH_W:0]   pkt_cnt;
  logic               ovf;
  logic [DATA_W:0]    rd;
  logic               empty;
  logic               full;
  logic               pkt_ok;
  logic               stall;
  logic               push;
  logic               pop;
  logic               push_last;
  logic               pop_last;

`ifdef IOB_AXIS_SIM_LOOPBACK_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lfsr <= LFSR_SEED ^ 16'(CH_IDX);
    end else if (cke_i) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign stall = (lfsr[1:0] & STALL_MASK) == 2'b00;
`else
  assign stall = 1'b0;
`endif

  assign rd    = mem[rptr];
  assign empty = level == '0;
  assign full  = level == FULL_LVL;

  // A full FIFO without a stored tlast is released anyway,
  // otherwise an oversize packet would wedge the channel.
  assign pkt_ok = (PKT_MODE == 0) || (pkt_cnt != '0) || full;

  assign s_tready_o = !full && !stall;
  assign m_tvalid_o = !empty && pkt_ok && !stall;
  assign m_tdata_o  = rd[DATA_W-1:0];
  assign m_tlast_o  = rd[DATA_W];
  assign level_o    = level;
  assign ovf_o      = ovf;

  assign push      = s_tvalid_i && s_tready_o;
  assign pop       = m_tvalid_o && m_tready_i;
  assign push_last = push && s_tlast_i;
  assign pop_last  = pop && rd[DATA_W];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      pkt_cnt <= '0;
      ovf     <= 1'b0;
    end else if (cke_i) begin
      if (flush_i) begin
        wptr    <= '0;
        rptr    <= '0;
        level   <= '0;
        pkt_cnt <= '0;
        ovf     <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= {s_tlast_i, s_tdata_i};
          wptr      <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
        unique case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
        unique case ({push_last, pop_last})
          2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
          2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
          default: ;
        endcase
        if (s_tvalid_i && full) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_axis_sim_loopback.sv
// iob_axis_sim_loopback: N_CH independent AXIS loopback channels
// for SoC simulation wrappers (buffer s_* beats, replay on m_*).
// Ports: clk_i, cke_i, arst_i, flush_i[N_CH]; s_t{valid,data,last}_i,
//   s_tready_o; m_t{valid,data,last}_o, m_tready_i; level_o, ovf_o.
// Macro IOB_AXIS_SIM_LOOPBACK_STALL_EN adds pseudo-random stalls.
module iob_axis_sim_loopback
  import iob_axis_sim_loopback_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH_W  = DEF_DEPTH_W,
  parameter int PKT_MODE = DEF_PKT_MODE
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      arst_i,
  input  logic [N_CH-1:0]           flush_i,
  input  logic [N_CH-1:0]           s_tvalid_i,
  input  logic [N_CH*DATA_W-1:0]    s_tdata_i,
  input  logic [N_CH-1:0]           s_tlast_i,
  output logic [N_CH-1:0]           s_tready_o,
  output logic [N_CH-1:0]           m_tvalid_o,
  output logic [N_CH*DATA_W-1:0]    m_tdata_o,
  output logic [N_CH-1:0]           m_tlast_o,
  input  logic [N_CH-1:0]           m_tready_i,
  output logic [N_CH*(DEPTH_W+1)-1:0] level_o,
  output logic [N_CH-1:0]           ovf_o
);

  localparam int LW = DEPTH_W + 1;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    iob_axis_sim_loopback_ch #(
      .DATA_W   (DATA_W),
      .DEPTH_W  (DEPTH_W),
      .PKT_MODE (PKT_MODE),
      .CH_IDX   (c)
    ) u_ch (
      .clk_i      (clk_i),
      .cke_i      (cke_i),
      .arst_i     (arst_i),
      .flush_i    (flush_i[c]),
      .s_tvalid_i (s_tvalid_i[c]),
      .s_tdata_i  (s_tdata_i[c*DATA_W +: DATA_W]),
      .s_tlast_i  (s_tlast_i[c]),
      .s_tready_o (s_tready_o[c]),
      .m_tvalid_o (m_tvalid_o[c]),
      .m_tdata_o  (m_tdata_o[c*DATA_W +: DATA_W]),
      .m_tlast_o  (m_tlast_o[c]),
      .m_tready_i (m_tready_i[c]),
      .level_o    (level_o[c*LW +: LW]),
      .ovf_o      (ovf_o[c])
    );
  end

endmodule

// File: tb/tb_iob_axis_sim_loopback.sv
// tb_iob_axis_sim_loopback: directed and random loopback checks
// on a 2-channel cut-through and a 1-channel packet-mode instance.
module tb_iob_axis_sim_loopback;

`ifdef IOB_AXIS_SIM_LOOPBACK_STALL_EN
  localparam int NB = 1000;
`else
  localparam int NB = 300;
`endif

  logic clk = 1'b0;
  logic cke;
  logic rst;

  logic [1:0]  a_flush, a_sv, a_sl, a_sr, a_mv, a_ml, a_mr, a_ovf;
  logic [63:0] a_sd, a_md;
  logic [5:0]  a_lvl;

  logic        b_flush, b_sv, b_sl, b_sr, b_mv, b_ml, b_mr, b_ovf;
  logic [31:0] b_sd, b_md;
  logic [2:0]  b_lvl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_axis_sim_loopback #(
    .N_CH(2), .DATA_W(32), .DEPTH_W(2), .PKT_MODE(0)
  ) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(rst), .flush_i(a_flush),
    .s_tvalid_i(a_sv), .s_tdata_i(a_sd), .s_tlast_i(a_sl),
    .s_tready_o(a_sr), .m_tvalid_o(a_mv), .m_tdata_o(a_md),
    .m_tlast_o(a_ml), .m_tready_i(a_mr), .level_o(a_lvl),
    .ovf_o(a_ovf)
  );

  iob_axis_sim_loopback #(
    .N_CH(1), .DATA_W(32), .DEPTH_W(2), .PKT_MODE(1)
  ) dut_pkt (
    .clk_i(clk), .cke_i(cke), .arst_i(rst), .flush_i(b_flush),
    .s_tvalid_i(b_sv), .s_tdata_i(b_sd), .s_tlast_i(b_sl),
    .s_tready_o(b_sr), .m_tvalid_o(b_mv), .m_tdata_o(b_md),
    .m_tlast_o(b_ml), .m_tready_i(b_mr), .level_o(b_lvl),
    .ovf_o(b_ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs;
    cke = 1'b1;
    a_flush = '0; a_sv = '0; a_sl = '0; a_mr = '0; a_sd = '0;
    b_flush = 1'b0; b_sv = 1'b0; b_sl = 1'b0; b_mr = 1'b0;
    b_sd = '0;
  endtask

  task automatic test_reset;
    init_inputs();
    rst = 1'b1;
    #2;
    n_chk++;
    if (a_sr !== 2'b11) begin
      n_fail++; $display("FAIL rst_sready got %b want 11", a_sr);
    end
    n_chk++;
    if (a_mv !== 2'b00 || a_ml !== 2'b00) begin
      n_fail++; $display("FAIL rst_mvalid got %b/%b want 00", a_mv, a_ml);
    end
    n_chk++;
    if (a_md !== 64'd0) begin
      n_fail++; $display("FAIL rst_mdata got %h want 0", a_md);
    end
    n_chk++;
    if (a_lvl !== 6'd0 || a_ovf !== 2'b00) begin
      n_fail++; $display("FAIL rst_lvl got %h/%b want 0", a_lvl, a_ovf);
    end
    n_chk++;
    if (b_sr !== 1'b1 || b_mv !== 1'b0) begin
      n_fail++; $display("FAIL rst_pkt got %b%b want 10", b_sr, b_mv);
    end
    tick(); tick();
    rst = 1'b0;
    a_sv[0] = 1'b1; a_sd[31:0] = 32'h1234;
    tick();
    a_sv[0] = 1'b0;
    n_chk++;
    if (a_mv[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_async got %b want 1", a_mv[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (a_mv !== 2'b00 || a_lvl !== 6'd0 || a_md !== 64'd0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b l=%h d=%h want 0", a_mv, a_lvl, a_md);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_cke;
    cke = 1'b0;
    a_sv[0] = 1'b1; a_sd[31:0] = 32'h5555;
    tick();
    n_chk++;
    if (a_lvl[2:0] !== 3'd0 || a_mv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cke_freeze got l=%0d v=%b want 0", a_lvl[2:0], a_mv[0]);
    end
    a_sv[0] = 1'b0;
    cke = 1'b1;
  endtask

  task automatic test_fill_ovf;
    a_mr = '0;
    for (int i = 0; i < 4; i++) begin
      a_sv[0] = 1'b1; a_sl[0] = 1'b0; a_sd[31:0] = 32'h100 + i;
      tick();
      if (i == 0) begin
        n_chk++;
        if (a_mv[0] !== 1'b1 || a_md[31:0] !== 32'h100) begin
          n_fail++;
          $display("FAIL fwft got v=%b d=%h want 1/100", a_mv[0], a_md[31:0]);
        end
      end
    end
    n_chk++;
    if (a_sr !== 2'b10) begin
      n_fail++; $display("FAIL full_ready got %b want 10", a_sr);
    end
    n_chk++;
    if (a_lvl[2:0] !== 3'd4 || a_lvl[5:3] !== 3'd0) begin
      n_fail++;
      $display("FAIL full_lvl got %0d/%0d want 4/0", a_lvl[2:0], a_lvl[5:3]);
    end
    n_chk++;
    if (a_md[31:0] !== 32'h100 || a_ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL hold got d=%h o=%b want 100/00", a_md[31:0], a_ovf);
    end
    tick();
    a_sv[0] = 1'b0;
    n_chk++;
    if (a_ovf !== 2'b01 || a_lvl[2:0] !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set got o=%b l=%0d want 01/4", a_ovf, a_lvl[2:0]);
    end
    tick();
    n_chk++;
    if (a_ovf[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky got %b want 1", a_ovf[0]);
    end
    a_flush[0] = 1'b1; a_mr[0] = 1'b1;
    tick();
    a_flush[0] = 1'b0; a_mr[0] = 1'b0;
    n_chk++;
    if (a_lvl[2:0] !== 3'd0 || a_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush got l=%0d o=%b want 0/0", a_lvl[2:0], a_ovf[0]);
    end
    n_chk++;
    if (a_mv[0] !== 1'b0 || a_sr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hs got v=%b r=%b want 0/1", a_mv[0], a_sr[0]);
    end
  endtask

  task automatic test_cut_through;
    a_mr[0] = 1'b1;
    a_sv[0] = 1'b1; a_sl[0] = 1'b1; a_sd[31:0] = 32'hDEAD_BEEF;
    tick();
    a_sv[0] = 1'b0; a_sl[0] = 1'b0;
    n_chk++;
    if (a_mv[0] !== 1'b1 || a_md[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ct_data got v=%b d=%h want 1/deadbeef", a_mv[0], a_md[31:0]);
    end
    n_chk++;
    if (a_ml[0] !== 1'b1 || a_lvl[2:0] !== 3'd1) begin
      n_fail++;
      $display("FAIL ct_last got t=%b l=%0d want 1/1", a_ml[0], a_lvl[2:0]);
    end
    tick();
    n_chk++;
    if (a_mv[0] !== 1'b0 || a_lvl[2:0] !== 3'd0) begin
      n_fail++;
      $display("FAIL ct_drain got v=%b l=%0d want 0/0", a_mv[0], a_lvl[2:0]);
    end
    a_mr[0] = 1'b0;
  endtask

  task automatic test_back_to_back;
    a_mr[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_sv[1] = 1'b1; a_sd[63:32] = 32'hA0 + i;
      tick();
      n_chk++;
      if (a_mv[1] !== 1'b1 || a_md[63:32] !== 32'hA0 + i ||
          a_lvl[5:3] !== 3'd1) begin
        n_fail++;
        $display("FAIL b2b_%0d got v=%b d=%h l=%0d want 1/%h/1",
                 i, a_mv[1], a_md[63:32], a_lvl[5:3], 32'hA0 + i);
      end
    end
    a_sv[1] = 1'b0;
    tick();
    n_chk++;
    if (a_lvl !== 6'd0 || a_mv !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_end got l=%h v=%b want 0/00", a_lvl, a_mv);
    end
    a_mr[1] = 1'b0;
  endtask

  task automatic test_pkt;
    logic [31:0] ev [3];
    ev[0] = 32'h11; ev[1] = 32'h22; ev[2] = 32'h33;
    b_mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_sv = 1'b1; b_sd = ev[i]; b_sl = (i == 2);
      tick();
      if (i < 2) begin
        n_chk++;
        if (b_mv !== 1'b0 || b_lvl !== 3'(i + 1)) begin
          n_fail++;
          $display("FAIL pkt_hold_%0d got v=%b l=%0d want 0/%0d",
                   i, b_mv, b_lvl, i + 1);
        end
      end
    end
    b_sv = 1'b0; b_sl = 1'b0;
    n_chk++;
    if (b_mv !== 1'b1 || b_md !== 32'h11 || b_ml !== 1'b0 ||
        b_lvl !== 3'd3) begin
      n_fail++;
      $display("FAIL pkt_rel got v=%b d=%h t=%b l=%0d want 1/11/0/3",
               b_mv, b_md, b_ml, b_lvl);
    end
    for (int j = 1; j < 3; j++) begin
      tick();
      n_chk++;
      if (b_mv !== 1'b1 || b_md !== ev[j] || b_ml !== (j == 2)) begin
        n_fail++;
        $display("FAIL pkt_out_%0d got v=%b d=%h t=%b want 1/%h",
                 j, b_mv, b_md, b_ml, ev[j]);
      end
    end
    tick();
    n_chk++;
    if (b_mv !== 1'b0 || b_lvl !== 3'd0) begin
      n_fail++;
      $display("FAIL pkt_end got v=%b l=%0d want 0/0", b_mv, b_lvl);
    end
    b_mr = 1'b0;
  endtask

  task automatic test_pkt_full;
    b_mr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_sv = 1'b1; b_sl = 1'b0; b_sd = 32'h40 + i;
      tick();
      if (i == 2) begin
        n_chk++;
        if (b_mv !== 1'b0) begin
          n_fail++; $display("FAIL pf_hold got %b want 0", b_mv);
        end
      end
    end
    b_sv = 1'b0;
    n_chk++;
    if (b_mv !== 1'b1 || b_md !== 32'h40 || b_sr !== 1'b0 ||
        b_lvl !== 3'd4) begin
      n_fail++;
      $display("FAIL pf_release got v=%b d=%h r=%b l=%0d want 1/40/0/4",
               b_mv, b_md, b_sr, b_lvl);
    end
    b_mr = 1'b1;
    tick();
    n_chk++;
    if (b_mv !== 1'b0 || b_lvl !== 3'd3 || b_md !== 32'h41) begin
      n_fail++;
      $display("FAIL pf_regate got v=%b l=%0d d=%h want 0/3/41",
               b_mv, b_lvl, b_md);
    end
    b_sv = 1'b1; b_sl = 1'b1; b_sd = 32'h44;
    tick();
    b_sv = 1'b0; b_sl = 1'b0;
    for (int j = 1; j < 5; j++) begin
      n_chk++;
      if (b_mv !== 1'b1 || b_md !== 32'h40 + j || b_ml !== (j == 4)) begin
        n_fail++;
        $display("FAIL pf_drain_%0d got v=%b d=%h t=%b want 1/%h",
                 j, b_mv, b_md, b_ml, 32'h40 + j);
      end
      tick();
    end
    n_chk++;
    if (b_mv !== 1'b0 || b_lvl !== 3'd0) begin
      n_fail++;
      $display("FAIL pf_end got v=%b l=%0d want 0/0", b_mv, b_lvl);
    end
    b_mr = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] q [$];
    int sent;
    int recv;
    int cyc;
    logic psh;
    logic pp;
    sent = 0; recv = 0; cyc = 0;
    a_sv[0] = 1'b0; a_sl[0] = 1'b0;
    while (recv < NB && cyc < 20 * NB) begin
      if (!a_sv[0] && sent < NB && $urandom_range(0, 3) != 0) begin
        a_sv[0] = 1'b1;
        a_sd[31:0] = $urandom;
      end
      a_mr[0] = ($urandom_range(0, 2) != 0);
      #1;
      psh = a_sv[0] & a_sr[0];
      pp  = a_mv[0] & a_mr[0];
      if (pp) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_dup got %h want no beat", a_md[31:0]);
        end else begin
          if (a_md[31:0] !== q[0]) begin
            n_fail++;
            $display("FAIL rnd_data beat %0d got %h want %h",
                     recv, a_md[31:0], q[0]);
          end
          void'(q.pop_front());
        end
        recv++;
      end
      if (psh) begin
        q.push_back(a_sd[31:0]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (psh) a_sv[0] = 1'b0;
    end
    a_sv[0] = 1'b0; a_mr[0] = 1'b0;
    n_chk++;
    if (recv != NB || q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_count got %0d beats (%0d left) want %0d",
               recv, q.size(), NB);
    end
  endtask

  initial begin
`ifndef IOB_AXIS_SIM_LOOPBACK_STALL_EN
    test_reset();
    test_cke();
    test_fill_ovf();
    test_cut_through();
    test_back_to_back();
    test_pkt();
    test_pkt_full();
`else
    init_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
